// File: rtl/sreg_tx_if.sv
// Request/serial-link bundle between a controller and the address shifter.
// master: the controller driving requests; slave: the transmitter itself.
interface sreg_tx_if #(
    parameter int WIDTH = 21
);
    logic             start;
    logic             inc;
    logic [WIDTH-1:0] addr;
    logic             si;
    logic             sclk;
    logic             sreg_en_n;
    logic             counter_n;
    logic             busy;
    logic             done;

    modport master (
        output start, inc, addr,
        input  si, sclk, sreg_en_n, counter_n, busy, done
    );

    modport slave (
        input  start, inc, addr,
        output si, sclk, sreg_en_n, counter_n, busy, done
    );
endinterface

// File: rtl/sreg_tx.sv
// Serial SRAM-address transmitter: shifts addr out MSB-first on si/sclk, or issues one counter pulse.
// Latency: transfer done 2*DIV*WIDTH+DIV+1 cycles after accept; increment done 2*DIV+1 cycles after accept.
// Backpressure: start/inc only sampled while idle or in the done cycle; ignored otherwise (busy high).
module sreg_tx #(
    parameter int WIDTH = 21,
    parameter int DIV   = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    sreg_tx_if.slave bus
);
    localparam int PW = $clog2(DIV) + 1;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHIFT_LO = 3'd1;
    localparam logic [2:0] S_SHIFT_HI = 3'd2;
    localparam logic [2:0] S_TAIL     = 3'd3;
    localparam logic [2:0] S_INC_LO   = 3'd4;
    localparam logic [2:0] S_INC_HI   = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]       st, st_nx;
    logic [PW-1:0]    ph, ph_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] sh, sh_nx;
    logic             last_ph;

    assign last_ph = (ph == PW'(DIV - 1));

    always_comb begin
        st_nx  = st;
        ph_nx  = ph + PW'(1);
        cnt_nx = cnt;
        sh_nx  = sh;
        case (st)
            S_IDLE, S_DONE: begin
                ph_nx = '0;
                if (bus.start) begin
                    sh_nx  = bus.addr;
                    cnt_nx = CW'(WIDTH);
                    st_nx  = S_SHIFT_LO;
                end else if (bus.inc) begin
                    st_nx = S_INC_LO;
                end else begin
                    st_nx = S_IDLE;
                end
            end
            S_SHIFT_LO: if (last_ph) begin
                ph_nx = '0;
                st_nx = S_SHIFT_HI;
            end
            S_SHIFT_HI: if (last_ph) begin
                ph_nx  = '0;
                sh_nx  = sh << 1;
                cnt_nx = cnt - CW'(1);
                st_nx  = (cnt == CW'(1)) ? S_TAIL : S_SHIFT_LO;
            end
            S_TAIL: if (last_ph) begin
                ph_nx = '0;
                st_nx = S_DONE;
            end
            S_INC_LO: if (last_ph) begin
                ph_nx = '0;
                st_nx = S_INC_HI;
            end
            S_INC_HI: if (last_ph) begin
                ph_nx = '0;
                st_nx = S_DONE;
            end
            default: begin
                ph_nx = '0;
                st_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st  <= S_IDLE;
            ph  <= '0;
            cnt <= '0;
            sh  <= '0;
        end else begin
            st  <= st_nx;
            ph  <= ph_nx;
            cnt <= cnt_nx;
            sh  <= sh_nx;
        end
    end

    // Outputs are flops loaded from the next-state decode, so they line up with the state register.
    logic nx_shift, nx_frame, nx_inc, nx_hi;
    assign nx_shift = (st_nx == S_SHIFT_LO) || (st_nx == S_SHIFT_HI);
    assign nx_frame = nx_shift || (st_nx == S_TAIL);
    assign nx_inc   = (st_nx == S_INC_LO) || (st_nx == S_INC_HI);
    assign nx_hi    = (st_nx == S_SHIFT_HI) || (st_nx == S_INC_HI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.si        <= 1'b0;
            bus.sclk      <= 1'b0;
            bus.sreg_en_n <= 1'b1;
            bus.counter_n <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.si        <= nx_shift ? sh_nx[WIDTH-1] : 1'b0;
            bus.sclk      <= nx_hi;
            bus.sreg_en_n <= !nx_frame;
            bus.counter_n <= !nx_inc;
            bus.busy      <= nx_frame || nx_inc;
            bus.done      <= (st_nx == S_DONE);
        end
    end
endmodule

// File: tb/tb_sreg_tx.sv
// Bench for sreg_tx: two instances (21-bit/DIV=2 and 8-bit/DIV=1), queued expectations vs. a receiver monitor.
module tb_sreg_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sreg_tx_if #(.WIDTH(21)) bus0 ();
    sreg_tx_if #(.WIDTH(8))  bus1 ();

    sreg_tx #(.WIDTH(21), .DIV(2)) u0 (.clk(clk), .reset_n(rst0), .bus(bus0));
    sreg_tx #(.WIDTH(8),  .DIV(1)) u1 (.clk(clk), .reset_n(rst1), .bus(bus1));

    typedef struct {
        int          dut;
        int          acc;
        logic [31:0] val;
        int          nrise, first, last, en, cn, busy, lat;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: what a receiver should observe for one operation, relative to its accept edge.
    function automatic exp_t model(int d, bit is_inc, logic [31:0] a, int acc);
        exp_t e;
        int   w;
        int   v;
        w = (d != 0) ? 8 : 21;
        v = (d != 0) ? 1 : 2;
        e.dut = d;
        e.acc = acc;
        if (!is_inc) begin
            e.val = a & ((32'd1 << w) - 32'd1);
            e.nrise = w;
            e.first = 1 + v;
            e.last  = 1 + v + 2 * v * (w - 1);
            e.en    = 2 * v * w + v;
            e.cn    = 0;
            e.busy  = 2 * v * w + v;
            e.lat   = 2 * v * w + v + 1;
        end else begin
            e.val = 32'd0;
            e.nrise = 1;
            e.first = v + 1;
            e.last  = v + 1;
            e.en    = 0;
            e.cn    = 2 * v;
            e.busy  = 2 * v;
            e.lat   = 2 * v + 1;
        end
        return e;
    endfunction

    // Receiver/monitor state per instance
    logic [31:0] rx [2];
    int nr [2], fr [2], lr [2], enl [2], cnl [2], bzc [2], gl [2];
    logic psclk [2], psi [2];

    task automatic clr(int d);
        rx[d] = 32'd0; nr[d] = 0; fr[d] = 0; lr[d] = 0;
        enl[d] = 0; cnl[d] = 0; bzc[d] = 0; gl[d] = 0;
        psclk[d] = 1'b0; psi[d] = 1'b0;
    endtask

    task automatic mon_step(int d, logic rn, logic si, logic sc, logic en, logic cn, logic bz, logic dn);
        exp_t        e;
        logic [31:0] mask;
        if (!rn) begin
            clr(d);
            return;
        end
        if (sc && !psclk[d]) begin
            rx[d] = {rx[d][30:0], si};
            nr[d]++;
            if (nr[d] == 1) fr[d] = cyc + 1;
            lr[d] = cyc + 1;
        end else if (sc && psclk[d] && (si !== psi[d])) begin
            gl[d]++;
        end
        if (!en) enl[d]++;
        if (!cn) cnl[d]++;
        if (bz) bzc[d]++;
        if (dn) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: dut %0d pulsed done at cycle %0d, required no pending op", d, cyc + 1);
            end else begin
                e = exp_q.pop_front();
                mask = (d != 0) ? 32'hFF : 32'h1FFFFF;
                chk("dut_id", d, e.dut);
                chk("rx_value", rx[d] & mask, e.val);
                chk("sclk_rises", nr[d], e.nrise);
                chk("first_rise", fr[d], e.acc + e.first);
                chk("last_rise", lr[d], e.acc + e.last);
                chk("en_low_cycles", enl[d], e.en);
                chk("cnt_low_cycles", cnl[d], e.cn);
                chk("busy_cycles", bzc[d], e.busy);
                chk("done_cycle", cyc + 1, e.acc + e.lat);
                chk("si_change_while_high", gl[d], 0);
            end
            clr(d);
        end
        psclk[d] = sc;
        psi[d]   = si;
    endtask

    always @(negedge clk) begin
        mon_step(0, rst0, bus0.si, bus0.sclk, bus0.sreg_en_n, bus0.counter_n, bus0.busy, bus0.done);
        mon_step(1, rst1, bus1.si, bus1.sclk, bus1.sreg_en_n, bus1.counter_n, bus1.busy, bus1.done);
    end

    task automatic drv(int d, logic s, logic i, logic [31:0] a);
        if (d == 0) begin
            bus0.start = s; bus0.inc = i; bus0.addr = a[20:0];
        end else begin
            bus1.start = s; bus1.inc = i; bus1.addr = a[7:0];
        end
    endtask

    task automatic chk_idle(string tag, int d);
        if (d == 0) begin
            chk({tag, "_si"}, bus0.si, 0);
            chk({tag, "_sclk"}, bus0.sclk, 0);
            chk({tag, "_en_n"}, bus0.sreg_en_n, 1);
            chk({tag, "_counter_n"}, bus0.counter_n, 1);
            chk({tag, "_busy"}, bus0.busy, 0);
            chk({tag, "_done"}, bus0.done, 0);
        end else begin
            chk({tag, "_si"}, bus1.si, 0);
            chk({tag, "_sclk"}, bus1.sclk, 0);
            chk({tag, "_en_n"}, bus1.sreg_en_n, 1);
            chk({tag, "_counter_n"}, bus1.counter_n, 1);
            chk({tag, "_busy"}, bus1.busy, 0);
            chk({tag, "_done"}, bus1.done, 0);
        end
    endtask

    // Called at a falling edge: request is sampled at the next rising edge (returned as acc).
    task automatic issue(int d, bit s, bit i, logic [31:0] a, output int acc);
        acc = cyc + 1;
        drv(d, s, i, a);
        exp_q.push_back(model(d, !s, a, acc));
        @(negedge clk);
        drv(d, 1'b0, 1'b0, $urandom);
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending_ops", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   a0;
        int   a1;
        exp_t e;
        rst0 = 1'b1;
        rst1 = 1'b1;
        drv(0, 1'b0, 1'b0, 32'd0);
        drv(1, 1'b0, 1'b0, 32'd0);
        #1 rst0 = 1'b0; rst1 = 1'b0;
        #1;
        chk_idle("reset0", 0);
        chk_idle("reset1", 1);
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b1;
        rst1 = 1'b1;
        @(negedge clk);

        // Directed transfer, defaults
        issue(0, 1'b1, 1'b0, 32'h1ABCDE, a0);
        drain();

        // Interference during a transfer
        issue(0, 1'b1, 1'b0, 32'h0FFFFF, a0);
        wait_cyc(a0 + 9);
        drv(0, 1'b1, 1'b1, 32'd0);
        @(negedge clk);
        drv(0, 1'b0, 1'b0, 32'd0);
        wait_cyc(a0 + 49);
        drv(0, 1'b1, 1'b1, 32'd0);
        @(negedge clk);
        drv(0, 1'b0, 1'b0, 32'd0);
        drain();

        // Increment, then start and inc together
        issue(0, 1'b0, 1'b1, $urandom, a0);
        drain();
        issue(0, 1'b1, 1'b1, 32'h155555, a0);
        drain();

        // Abort mid-frame with an asynchronous reset
        issue(0, 1'b1, 1'b0, 32'h1FFFFF, a0);
        wait_cyc(a0 + 39);
        #2 rst0 = 1'b0;
        void'(exp_q.pop_back());
        #1 chk_idle("abort", 0);
        wait_cyc(a0 + 44);
        chk_idle("abort_hold", 0);
        rst0 = 1'b1;
        @(negedge clk);
        issue(0, 1'b1, 1'b0, 32'h000001, a0);
        drain();

        // Randomized operations on the default instance
        for (int i = 0; i < 10; i++) begin
            bit k;
            k = 1'($urandom_range(0, 1));
            issue(0, !k, k, $urandom, a0);
            drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Narrow, fast instance
        issue(1, 1'b1, 1'b0, 32'hA5, a0);
        drain();
        issue(1, 1'b0, 1'b1, 32'h00, a0);
        drain();

        // Start held high: frames follow each other from the done cycle
        a0 = cyc + 1;
        drv(1, 1'b1, 1'b0, 32'h5A);
        for (int f = 0; f < 3; f++) begin
            e = model(1, 1'b0, 32'h5A, a0 + 18 * f);
            exp_q.push_back(e);
        end
        a1 = a0 + 36;
        wait_cyc(a1);
        drv(1, 1'b0, 1'b0, 32'd0);
        drain();

        for (int i = 0; i < 6; i++) begin
            bit k;
            k = 1'($urandom_range(0, 1));
            issue(1, !k, k, $urandom, a0);
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
